// File: rtl/breakout_pkg.sv
// Shared definitions for the breakout game datapath, sequencer and HUD.
package breakout_pkg;

   localparam int BRICK_ROWS_DEF = 5;
   localparam int BRICK_COLS_DEF = 10;
   localparam int NUM_BRICKS     = BRICK_ROWS_DEF * BRICK_COLS_DEF;

   localparam int LIVES_W = 3;
   localparam int LEVEL_W = 4;

   localparam logic [LEVEL_W-1:0] LEVEL_MAX = 4'd15;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_SERVE     = 3'd1,
      ST_PLAY      = 3'd2,
      ST_LOSE      = 3'd3,
      ST_LEVEL_UP  = 3'd4,
      ST_GAME_OVER = 3'd5
   } game_state_t;

endpackage

// File: rtl/breakout_game_ctrl_edge_pulse.sv
// Rising-edge detector: compares a level input against its registered copy,
// so a held level yields a single high cycle.
module edge_pulse (
   input  logic clk,
   input  logic rst_n,
   input  logic i_level,
   output logic o_rise
);

   logic r_level_q;

   // Delayed copy of the level input
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_level_q <= 1'b0;
      else        r_level_q <= i_level;
   end

   assign o_rise = i_level & ~r_level_q;

endmodule

// File: rtl/breakout_game_ctrl.sv
// Breakout game sequencer: serve timing, ball gating, brick reload,
// score / lives / level bookkeeping.
//
// state      | meaning
// -----------+--------------------------------------------------------
// IDLE       | power-up, waiting for start
// SERVE      | ball held on paddle, counting frame ticks before launch
// PLAY       | ball moving, scoring hits, watching for clear / loss
// LOSE       | one cycle: take a life, re-serve or end the game
// LEVEL_UP   | one cycle: bump level, reload bricks, re-serve
// GAME_OVER  | final score shown, waiting for start
module breakout_game_ctrl
   import breakout_pkg::*;
#(
   parameter int BRICK_ROWS         = BRICK_ROWS_DEF,
   parameter int BRICK_COLS         = BRICK_COLS_DEF,
   parameter int START_LIVES        = 3,
   parameter int SERVE_DELAY_FRAMES = 60,
   parameter int SCORE_WIDTH        = 14
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             i_frame_tick,
   input  logic                             i_start_btn,
   input  logic                             i_brick_hit,
   input  logic [BRICK_ROWS*BRICK_COLS-1:0] i_brick_state,
   input  logic                             i_ball_lost,
   output logic                             o_ball_enable,
   output logic                             o_ball_reset,
   output logic                             o_brick_reload,
   output logic [SCORE_WIDTH-1:0]           o_score,
   output logic [LIVES_W-1:0]               o_lives,
   output logic [LEVEL_W-1:0]               o_level,
   output logic                             o_game_over,
   output logic [2:0]                       o_state
);

   localparam int CNT_W = (SERVE_DELAY_FRAMES > 1) ? $clog2(SERVE_DELAY_FRAMES) : 1;
   localparam logic [CNT_W-1:0] SERVE_LAST = CNT_W'(SERVE_DELAY_FRAMES - 1);

   game_state_t            r_state;
   logic [CNT_W-1:0]       r_serve_cnt;
   logic [SCORE_WIDTH-1:0] r_score;
   logic [LIVES_W-1:0]     r_lives;
   logic [LEVEL_W-1:0]     r_level;
   logic                   r_ball_enable;
   logic                   r_ball_reset;
   logic                   r_brick_reload;
   logic                   r_game_over;
   logic                   w_start;

   edge_pulse u_start_edge (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_level (i_start_btn),
      .o_rise  (w_start)
   );

   // Game FSM with its counters and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state        <= ST_IDLE;
         r_serve_cnt    <= '0;
         r_score        <= '0;
         r_lives        <= '0;
         r_level        <= '0;
         r_ball_enable  <= 1'b0;
         r_ball_reset   <= 1'b0;
         r_brick_reload <= 1'b0;
         r_game_over    <= 1'b0;
      end else begin
         r_ball_reset   <= 1'b0;
         r_brick_reload <= 1'b0;
         case (r_state)
            ST_IDLE, ST_GAME_OVER: begin
               r_ball_enable <= 1'b0;
               if (w_start) begin
                  r_score        <= '0;
                  r_lives        <= LIVES_W'(START_LIVES);
                  r_level        <= LEVEL_W'(1);
                  r_brick_reload <= 1'b1;
                  r_ball_reset   <= 1'b1;
                  r_serve_cnt    <= '0;
                  r_game_over    <= 1'b0;
                  r_state        <= ST_SERVE;
               end
            end
            ST_SERVE: begin
               r_ball_enable <= 1'b0;
               if (i_frame_tick) begin
                  if (r_serve_cnt == SERVE_LAST) begin
                     r_ball_enable <= 1'b1;
                     r_state       <= ST_PLAY;
                  end else begin
                     r_serve_cnt <= r_serve_cnt + 1'b1;
                  end
               end
            end
            ST_PLAY: begin
               if (i_brick_hit && (r_score != {SCORE_WIDTH{1'b1}}))
                  r_score <= r_score + 1'b1;
               // A cleared field outranks a lost ball in the same cycle
               if (i_brick_state == '0) begin
                  r_ball_enable <= 1'b0;
                  r_state       <= ST_LEVEL_UP;
               end else if (i_ball_lost) begin
                  r_ball_enable <= 1'b0;
                  r_state       <= ST_LOSE;
               end
            end
            ST_LOSE: begin
               r_ball_enable <= 1'b0;
               if (r_lives > LIVES_W'(1)) begin
                  r_lives      <= r_lives - 1'b1;
                  r_ball_reset <= 1'b1;
                  r_serve_cnt  <= '0;
                  r_state      <= ST_SERVE;
               end else begin
                  r_lives     <= '0;
                  r_game_over <= 1'b1;
                  r_state     <= ST_GAME_OVER;
               end
            end
            ST_LEVEL_UP: begin
               r_ball_enable <= 1'b0;
               if (r_level != LEVEL_MAX) r_level <= r_level + 1'b1;
               r_brick_reload <= 1'b1;
               r_ball_reset   <= 1'b1;
               r_serve_cnt    <= '0;
               r_state        <= ST_SERVE;
            end
            default: begin
               r_state        <= ST_IDLE;
               r_serve_cnt    <= '0;
               r_score        <= '0;
               r_lives        <= '0;
               r_level        <= '0;
               r_ball_enable  <= 1'b0;
               r_ball_reset   <= 1'b0;
               r_brick_reload <= 1'b0;
               r_game_over    <= 1'b0;
            end
         endcase
      end
   end

   assign o_ball_enable  = r_ball_enable;
   assign o_ball_reset   = r_ball_reset;
   assign o_brick_reload = r_brick_reload;
   assign o_score        = r_score;
   assign o_lives        = r_lives;
   assign o_level        = r_level;
   assign o_game_over    = r_game_over;
   assign o_state        = r_state;

endmodule

// File: tb/tb_breakout_game_ctrl.sv
// Bench for breakout_game_ctrl: game-rule model checked every cycle plus
// directed literal expectations along a scripted game.
module tb_breakout_game_ctrl;

   localparam int ROWS      = 5;
   localparam int COLS      = 10;
   localparam int NB        = ROWS * COLS;
   localparam int LIVES0    = 3;
   localparam int SERVE     = 4;
   localparam int SW        = 4;
   localparam int SCORE_MAX = (1 << SW) - 1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          i_frame_tick = 1'b0;
   logic          i_start_btn = 1'b0;
   logic          i_brick_hit = 1'b0;
   logic [NB-1:0] i_brick_state = '1;
   logic          i_ball_lost = 1'b0;
   logic          o_ball_enable, o_ball_reset, o_brick_reload, o_game_over;
   logic [SW-1:0] o_score;
   logic [2:0]    o_lives;
   logic [3:0]    o_level;
   logic [2:0]    o_state;

   int checks = 0;
   int errors = 0;

   breakout_game_ctrl #(
      .BRICK_ROWS         (ROWS),
      .BRICK_COLS         (COLS),
      .START_LIVES        (LIVES0),
      .SERVE_DELAY_FRAMES (SERVE),
      .SCORE_WIDTH        (SW)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .i_frame_tick   (i_frame_tick),
      .i_start_btn    (i_start_btn),
      .i_brick_hit    (i_brick_hit),
      .i_brick_state  (i_brick_state),
      .i_ball_lost    (i_ball_lost),
      .o_ball_enable  (o_ball_enable),
      .o_ball_reset   (o_ball_reset),
      .o_brick_reload (o_brick_reload),
      .o_score        (o_score),
      .o_lives        (o_lives),
      .o_level        (o_level),
      .o_game_over    (o_game_over),
      .o_state        (o_state)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Game-rule model: phase 0 idle, 1 serve, 2 play, 3 lose, 4 level-up, 5 over
   int m_phase = 0, m_score = 0, m_lives = 0, m_level = 0, m_ticks = 0;
   int m_btn_prev = 0, m_reload = 0, m_reset_ball = 0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_phase = 0; m_score = 0; m_lives = 0; m_level = 0; m_ticks = 0;
         m_btn_prev = 0; m_reload = 0; m_reset_ball = 0;
      end else begin
         int pressed;
         pressed = (i_start_btn && m_btn_prev == 0) ? 1 : 0;
         m_btn_prev = i_start_btn ? 1 : 0;
         m_reload = 0;
         m_reset_ball = 0;
         if (m_phase == 0 || m_phase == 5) begin
            if (pressed == 1) begin
               m_score = 0; m_lives = LIVES0; m_level = 1; m_ticks = 0;
               m_reload = 1; m_reset_ball = 1; m_phase = 1;
            end
         end else if (m_phase == 1) begin
            if (i_frame_tick) begin
               m_ticks = m_ticks + 1;
               if (m_ticks >= SERVE) m_phase = 2;
            end
         end else if (m_phase == 2) begin
            if (i_brick_hit && m_score < SCORE_MAX) m_score = m_score + 1;
            if (i_brick_state == '0) m_phase = 4;
            else if (i_ball_lost) m_phase = 3;
         end else if (m_phase == 3) begin
            if (m_lives > 1) begin
               m_lives = m_lives - 1; m_reset_ball = 1; m_ticks = 0; m_phase = 1;
            end else begin
               m_lives = 0; m_phase = 5;
            end
         end else if (m_phase == 4) begin
            m_level = (m_level + 1 > 15) ? 15 : m_level + 1;
            m_reload = 1; m_reset_ball = 1; m_ticks = 0; m_phase = 1;
         end
      end
   end

   // Compare every output against the model on the falling edge
   always @(negedge clk) begin
      chk("state",        int'(o_state),        m_phase);
      chk("score",        int'(o_score),        m_score);
      chk("lives",        int'(o_lives),        m_lives);
      chk("level",        int'(o_level),        m_level);
      chk("ball_enable",  int'(o_ball_enable),  (m_phase == 2) ? 1 : 0);
      chk("game_over",    int'(o_game_over),    (m_phase == 5) ? 1 : 0);
      chk("ball_reset",   int'(o_ball_reset),   m_reset_ball);
      chk("brick_reload", int'(o_brick_reload), m_reload);
   end

   // One clock with the given pulses, called just after a falling edge
   task automatic step(input logic hit, input logic lost, input logic tick);
      i_brick_hit  = hit;
      i_ball_lost  = lost;
      i_frame_tick = tick;
      @(negedge clk);
      i_brick_hit  = 1'b0;
      i_ball_lost  = 1'b0;
      i_frame_tick = 1'b0;
   endtask

   task automatic serve_ticks(input int n);
      for (int k = 0; k < n; k++) begin
         step(1'b0, 1'b0, 1'b0);
         step(1'b0, 1'b0, 1'b1);
      end
   endtask

   task automatic level_up();
      i_brick_state = '0;
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      i_brick_state = '1;
      serve_ticks(SERVE);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_state", int'(o_state), 0);
      chk("rst_lives", int'(o_lives), 0);
      chk("rst_level", int'(o_level), 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Start: one reload / ball_reset pulse, game values loaded
      i_start_btn = 1'b1;
      step(1'b0, 1'b0, 1'b0);
      chk("start_state",  int'(o_state), 1);
      chk("start_lives",  int'(o_lives), 3);
      chk("start_level",  int'(o_level), 1);
      chk("start_reload", int'(o_brick_reload), 1);
      chk("start_breset", int'(o_ball_reset), 1);
      step(1'b0, 1'b0, 1'b0);
      chk("reload_once",  int'(o_brick_reload), 0);
      i_start_btn = 1'b0;

      // Hits ignored while serving; launch after the 4th tick
      step(1'b1, 1'b0, 1'b0);
      chk("serve_hit", int'(o_score), 0);
      serve_ticks(3);
      chk("serve_hold", int'(o_state), 1);
      step(1'b0, 1'b0, 1'b1);
      chk("launch_state", int'(o_state), 2);
      chk("launch_en",    int'(o_ball_enable), 1);

      repeat (5) step(1'b1, 1'b0, 1'b0);
      chk("score5", int'(o_score), 5);
      repeat (20) step(1'b1, 1'b0, 1'b0);
      chk("score_sat", int'(o_score), 15);

      // Ball lost with a tick landing on the LOSE cycle (not counted)
      step(1'b0, 1'b1, 1'b0);
      chk("lose_state", int'(o_state), 3);
      step(1'b0, 1'b0, 1'b1);
      chk("lose_lives",  int'(o_lives), 2);
      chk("lose_breset", int'(o_ball_reset), 1);
      serve_ticks(3);
      chk("lose_serve_hold", int'(o_state), 1);
      serve_ticks(1);
      chk("relaunch", int'(o_state), 2);

      // Cleared field with ball_lost and hit in the same cycle
      i_brick_state = '0;
      step(1'b1, 1'b1, 1'b0);
      chk("clear_wins", int'(o_state), 4);
      step(1'b0, 1'b0, 1'b0);
      chk("lvl2",        int'(o_level), 2);
      chk("lvl2_lives",  int'(o_lives), 2);
      chk("lvl2_reload", int'(o_brick_reload), 1);
      step(1'b0, 1'b0, 1'b1);
      i_brick_state = '1;
      serve_ticks(3);
      chk("lvl2_play", int'(o_state), 2);

      for (int n = 0; n < 14; n++) level_up();
      chk("level_sat", int'(o_level), 15);

      // Down to one life, then game over with start held across entry
      step(1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      chk("one_life", int'(o_lives), 1);
      serve_ticks(SERVE);
      i_start_btn = 1'b1;
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      chk("go_state", int'(o_state), 5);
      chk("go_flag",  int'(o_game_over), 1);
      chk("go_lives", int'(o_lives), 0);
      chk("go_score", int'(o_score), 15);
      repeat (3) step(1'b0, 1'b0, 1'b0);
      chk("go_held_btn", int'(o_state), 5);
      i_start_btn = 1'b0;
      step(1'b0, 1'b0, 1'b0);
      i_start_btn = 1'b1;
      step(1'b0, 1'b0, 1'b0);
      i_start_btn = 1'b0;
      chk("restart_state", int'(o_state), 1);
      chk("restart_score", int'(o_score), 0);
      chk("restart_lives", int'(o_lives), 3);
      serve_ticks(SERVE);
      step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      chk("score2", int'(o_score), 2);

      // Asynchronous reset between clock edges mid-play
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_state", int'(o_state), 0);
      chk("arst_score", int'(o_score), 0);
      chk("arst_en",    int'(o_ball_enable), 0);
      chk("arst_lives", int'(o_lives), 0);
      @(negedge clk);
      step(1'b0, 1'b0, 1'b0);
      rst_n = 1'b1;
      step(1'b1, 1'b0, 1'b0);
      chk("idle_hit", int'(o_score), 0);
      repeat (2) step(1'b0, 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/breakout_game_ctrl.md
Name: breakout_game_ctrl

Overview:
Top-level game sequencer for the breakout datapath. It controls when the ball may move and when it is re-served, and when the brick field is reloaded. It also keeps score, lives and level, consuming the brick collision unit's hit pulse and live-brick bitmap. It sits between the brick/ball/paddle datapath blocks and the HUD renderer, on the single pixel-domain clock.

Parameters:
BRICK_ROWS, 5, rows in the brick field
BRICK_COLS, 10, columns in the brick field
START_LIVES, 3, lives granted at game start (1..7)
SERVE_DELAY_FRAMES, 60, frame ticks the ball is held before launch (>=1)
SCORE_WIDTH, 14, score counter width

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
frame_tick  in  1  one-cycle pulse per video frame
start_btn  in  1  debounced start button, level
brick_hit  in  1  one-cycle pulse, a brick was destroyed
brick_state  in  BRICK_ROWS*BRICK_COLS  live-brick bitmap (1 = present)
ball_lost  in  1  one-cycle pulse, ball passed below the paddle
ball_enable  out  1  ball motion permitted
ball_reset  out  1  one-cycle pulse, recentre the ball on the paddle
brick_reload  out  1  one-cycle pulse, restore all bricks
score  out  SCORE_WIDTH  current score
lives  out  3  remaining lives
level  out  4  current level, 1..15
game_over  out  1  high while in GAME_OVER
state  out  3  encoded FSM state, for debug and HUD

Behaviour:
- Reset (rst_n low, asynchronous) sets:
  - state = IDLE; score = 0; lives = 0; level = 0.
  - ball_enable = 0; ball_reset = 0; brick_reload = 0; game_over = 0.
  - Serve counter = 0; start edge register = 0.
  - Reset mid-game abandons everything. No pulse is emitted on reset release.
- Start is the rising edge of start_btn, detected against a registered copy. A held button produces one start only.
- All outputs are registered. Pulses last exactly one clk cycle.
- States: IDLE=0, SERVE=1, PLAY=2, LOSE=3, LEVEL_UP=4, GAME_OVER=5.
- IDLE: on start, next cycle:
  - score = 0, lives = START_LIVES, level = 1.
  - brick_reload = 1, ball_reset = 1, serve counter = 0.
  - Go to SERVE.
- SERVE:
  - ball_enable = 0.
  - Each frame_tick increments the counter.
  - On the frame_tick where the counter equals SERVE_DELAY_FRAMES-1, go to PLAY. ball_enable becomes 1 on the PLAY entry cycle.
  - brick_hit, ball_lost and brick_state are ignored in SERVE.
- PLAY: ball_enable = 1.
  - brick_hit: score += 1, saturating at all-ones.
  - Field cleared (brick_state == 0): go to LEVEL_UP.
  - ball_lost: go to LOSE.
  - Cleared and ball_lost in the same cycle: cleared wins. No life is lost.
  - brick_hit in the same cycle as either is still scored.
- LOSE (one cycle): ball_enable = 0.
  - If lives > 1: lives -= 1, ball_reset = 1, counter = 0, go to SERVE.
  - Otherwise: lives = 0, go to GAME_OVER.
- LEVEL_UP (one cycle): ball_enable = 0.
  - level += 1, saturating at 15.
  - brick_reload = 1, ball_reset = 1, counter = 0, go to SERVE.
  - lives and score are unchanged.
- GAME_OVER:
  - game_over = 1; ball_enable = 0; score, level and lives are held.
  - On start, behave exactly as the IDLE start.
- Brick reload settles before it is checked: brick_reload is issued on SERVE entry, and SERVE lasts >= 1 frame. The stale all-zero bitmap is therefore never seen in PLAY.
- frame_tick coincident with a state transition into SERVE does not count.
- Unused state encodings (6, 7) recover to IDLE on the next cycle with all outputs at reset values.

Decomposition:
- Shared package breakout_pkg holds:
  - The state encoding constants.
  - NUM_BRICKS = BRICK_ROWS*BRICK_COLS.
  - LIVES_W = 3 and LEVEL_W = 4.
  - LEVEL_MAX = 15.
- The package is reused by the brick logic and the HUD.
- One natural sub-module: edge_pulse, a registered rising-edge detector for start_btn.
- Counters and the FSM stay in this block.

Test Plan:
- Start from IDLE (SERVE_DELAY_FRAMES=4): pulse start_btn.
  - Next cycle: brick_reload=1 and ball_reset=1 for one cycle; lives=3, level=1, score=0, state=SERVE.
  - After the 4th frame_tick: state=PLAY, ball_enable=1.
- In PLAY: 5 brick_hit pulses -> score=5. With SCORE_WIDTH=4 and 20 hits -> score holds at 15.
- In PLAY with lives=3: ball_lost pulse -> LOSE, then SERVE; lives=2, one ball_reset pulse, ball_enable=0 for 4 frames.
- lives=1, ball_lost -> GAME_OVER with game_over=1, lives=0, score retained. Holding start_btn high across entry -> no restart until it is released and pressed again.
- In PLAY: drive brick_state=0 in the same cycle as ball_lost -> LEVEL_UP; level=2, lives unchanged, brick_reload pulse. Repeating from level 15 keeps level=15.
- Assert rst_n low mid-PLAY -> outputs return to reset values asynchronously with no pulses. brick_hit in SERVE/IDLE -> score unchanged.
